serial_port_bridge: RTL
=======================

// Module: serial_port_bridge
// PURPOSE
//  Byte-wide buffered bridge between the datapath's memory-mapped serial port and the
//  external serial link. Downstream neighbour of the datapath serial signals:
//  - consumes serial_out / serial_wren_out into a TX FIFO;
//  - returns serial_in / serial_valid_in / serial_ready_in from an RX FIFO;
//  - pops the RX FIFO on serial_rden_out.
//  The external side uses valid/ready byte handshakes.
// PARAMETERS
//  DEPTH_LOG2  4  log2 of each FIFO depth (16 entries); legal range 1..8
// PORTS
//  clock            in   1  single system clock; all state updates on rising edge
//  reset            in   1  asynchronous, active-low reset
//  cpu_wdata_in     in   8  TX byte from datapath serial_out
//  cpu_wren_in      in   1  TX push strobe from serial_wren_out
//  cpu_rden_in      in   1  RX pop strobe from serial_rden_out
//  cpu_rdata_out    out  8  RX head byte, drives datapath serial_in
//  cpu_rvalid_out   out  1  RX FIFO non-empty, drives serial_valid_in
//  cpu_wready_out   out  1  TX FIFO not full, drives serial_ready_in
//  ext_tx_data_out  out  8  byte offered to external link
//  ext_tx_valid_out out  1  TX FIFO non-empty
//  ext_tx_ready_in  in   1  external link accepts ext_tx_data_out
//  ext_rx_data_in   in   8  byte from external link
//  ext_rx_valid_in  in   1  external byte present
//  ext_rx_ready_out out  1  RX FIFO not full
//  tx_drop_out      out  1  sticky: CPU push attempted while TX full
//  rx_drop_out      out  1  sticky: never set; ext side is back-pressured (reserved, 0)
// BEHAVIOUR
//  - Reset (reset==0, async): both FIFOs empty, pointers/counts 0, sticky flags 0.
//    Output values during reset: cpu_rdata_out=8'h00, cpu_rvalid_out=0, ext_tx_valid_out=0,
//    ext_tx_data_out=8'h00, cpu_wready_out=1, ext_rx_ready_out=1.
//  - Reset mid-operation discards all buffered bytes immediately.
//  - FIFOs are first-word-fall-through:
//    - head data and valid are combinational from storage/count;
//    - empty FIFO drives data 8'h00.
//  - TX push: cpu_wren_in & cpu_wready_out at edge N; byte is visible on ext_tx_data_out
//    with ext_tx_valid_out=1 after edge N (1-cycle latency when previously empty).
//  - TX push while full: byte dropped, tx_drop_out set to 1 until reset. A same-cycle
//    external pop does NOT create room for the push (no full bypass).
//  - TX pop: ext_tx_valid_out & ext_tx_ready_in at the edge.
//  - RX push: ext_rx_valid_in & ext_rx_ready_out. RX pop: cpu_rden_in & cpu_rvalid_out.
//  - Pop while empty: ignored, no state change. A same-cycle push into an empty FIFO
//    is accepted; the pop is ignored (no empty bypass).
//  - Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged, both
//    pointers advance.
//  - Pointers are DEPTH_LOG2 bits and wrap modulo 2**DEPTH_LOG2.
//  - Count is DEPTH_LOG2+1 bits; full when count == 2**DEPTH_LOG2.
//  - No FSM beyond the FIFO occupancy; ordering within each direction is strictly FIFO.
// CONFIGURATION
//  SERIAL_LOOPBACK_EN defined:
//  - adds input port loopback_in (1 bit);
//  - while loopback_in=1:
//    - TX FIFO head feeds RX FIFO push (pop when RX not full);
//    - ext_tx_valid_out=0 and ext_rx_ready_out=0;
//    - ext inputs are ignored.
//  SERIAL_LOOPBACK_EN undefined: no loopback_in port; external path always active.
// STRUCTURE
//  - Shared package serial_pkg:
//    - SERIAL_BYTE_W=8;
//    - SERIAL_DEPTH_LOG2_DEFAULT=4;
//    - SERIAL_EMPTY_DATA=8'h00.
//  - One sub-module, byte_fifo: FWFT, parameterised by DEPTH_LOG2.
//    - ports: clock, reset, push, push_data, pop, head_data, empty, full;
//    - instantiated twice (tx_fifo, rx_fifo).
//  - The bridge adds the drop flag, loopback steering and output mapping.
// TESTING
//  - Reset check: assert reset=0 mid-stream with 3 bytes queued -> all valids 0,
//    cpu_wready_out=1 and ext_rx_ready_out=1, while reset is low and after release.
//  - TX order: push 8'hA5 then 8'h3C with ext_tx_ready_in=0, then raise ready ->
//    ext_tx_data_out shows A5, then 3C, then ext_tx_valid_out=0.
//  - TX full (DEPTH_LOG2=4): push 17 bytes 0..16 with ready=0 -> cpu_wready_out=0 after
//    16, byte 16 dropped, tx_drop_out=1; drain yields 0..15.
//  - RX FWFT: drive ext_rx 8'h41 for one cycle -> cpu_rvalid_out=1, cpu_rdata_out=8'h41
//    next cycle; pulse cpu_rden_in -> rvalid=0, rdata=8'h00.
//  - Wrap: 40 bytes streamed with random ready/rden throttling -> exact in-order match,
//    count never exceeds 16.
//  - SERIAL_LOOPBACK_EN with loopback_in=1: push 8'h5A -> cpu_rdata_out=8'h5A within
//    2 cycles, ext_tx_valid_out stays 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants and types for the serial port bridge.
package serial_pkg;

  localparam int SERIAL_BYTE_W             = 8;
  localparam int SERIAL_DEPTH_LOG2_DEFAULT = 4;

  typedef logic [SERIAL_BYTE_W-1:0] serial_byte_t;

  localparam serial_byte_t SERIAL_EMPTY_DATA = 8'h00;

endpackage

// File: rtl/serial_port_bridge_byte_fifo.sv
// byte_fifo: first-word-fall-through byte FIFO, 2**DEPTH_LOG2 entries.
// Head data and empty/full are combinational from storage and occupancy;
// an empty FIFO presents SERIAL_EMPTY_DATA. Push while full and pop while
// empty are ignored, so a same-cycle pop never frees room for a push and a
// same-cycle push never feeds a pop.
module byte_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH_LOG2 = SERIAL_DEPTH_LOG2_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  serial_byte_t push_data,
  input  logic         pop,
  output serial_byte_t head_data,
  output logic         empty,
  output logic         full
);

  localparam int                    DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);

  serial_byte_t          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage carries no reset; stale entries are never visible because the
  // head is gated by empty.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at their width; count tracks occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Fall-through head byte.
  always_comb begin
    head_data = SERIAL_EMPTY_DATA;
    if (!empty) begin
      head_data = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/serial_port_bridge.sv
// serial_port_bridge: buffered byte bridge between the datapath serial port
// and an external valid/ready byte link. One FWFT FIFO per direction.
// Optional feature macro SERIAL_LOOPBACK_EN adds loopback_in, which steers
// the TX FIFO head straight into the RX FIFO and isolates the external link.
module serial_port_bridge
  import serial_pkg::*;
#(
  parameter int DEPTH_LOG2 = SERIAL_DEPTH_LOG2_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
`ifdef SERIAL_LOOPBACK_EN
  input  logic         loopback_in,
`endif
  input  serial_byte_t cpu_wdata_in,
  input  logic         cpu_wren_in,
  input  logic         cpu_rden_in,
  output serial_byte_t cpu_rdata_out,
  output logic         cpu_rvalid_out,
  output logic         cpu_wready_out,
  output serial_byte_t ext_tx_data_out,
  output logic         ext_tx_valid_out,
  input  logic         ext_tx_ready_in,
  input  serial_byte_t ext_rx_data_in,
  input  logic         ext_rx_valid_in,
  output logic         ext_rx_ready_out,
  output logic         tx_drop_out,
  output logic         rx_drop_out
);

  logic         loopback;
  serial_byte_t tx_head;
  logic         tx_empty;
  logic         tx_full;
  logic         tx_pop;
  serial_byte_t rx_head;
  logic         rx_empty;
  logic         rx_full;
  logic         rx_push;
  serial_byte_t rx_push_data;
  logic         tx_drop;

`ifdef SERIAL_LOOPBACK_EN
  assign loopback = loopback_in;
`else
  assign loopback = 1'b0;
`endif

  // Direction steering: in loopback the TX head moves into RX whenever RX
  // has room; otherwise each FIFO talks to its external handshake.
  always_comb begin
    tx_pop       = ext_tx_ready_in;
    rx_push      = ext_rx_valid_in;
    rx_push_data = ext_rx_data_in;
    if (loopback) begin
      tx_pop       = ~rx_full & ~tx_empty;
      rx_push      = ~rx_full & ~tx_empty;
      rx_push_data = tx_head;
    end
  end

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (cpu_wren_in),
    .push_data (cpu_wdata_in),
    .pop       (tx_pop),
    .head_data (tx_head),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (cpu_rden_in),
    .head_data (rx_head),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  // Sticky record of any CPU byte lost to a full TX FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_drop <= 1'b0;
    end else if (cpu_wren_in && tx_full) begin
      tx_drop <= 1'b1;
    end
  end

  assign cpu_rdata_out    = rx_head;
  assign cpu_rvalid_out   = ~rx_empty;
  assign cpu_wready_out   = ~tx_full;
  assign ext_tx_data_out  = tx_head;
  assign ext_tx_valid_out = ~tx_empty & ~loopback;
  assign ext_rx_ready_out = ~rx_full & ~loopback;
  assign tx_drop_out      = tx_drop;
  // The external RX side is back-pressured, so nothing can be lost there.
  assign rx_drop_out      = 1'b0;

endmodule
